// File: rtl/ads1292_spi_responder.sv
// ADS1292 SPI responder: cycle-based model of the AFE's SPI slave side,
// register file and DRDY-flagged 72-bit data frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OPC   | waiting for an opcode byte
// ST_CNT   | WREG/RREG address latched, waiting for the count byte
// ST_WDATA | writing incoming bytes to reg[addr], addr++ per byte
// ST_RDATA | shifting reg[addr] out on MISO, addr++ per byte
// ST_FRAME | RDATA opcode: shifting the 72-bit frame buffer out
module ads1292_spi_responder #(
  parameter logic [7:0] ID_VALUE     = 8'h73,
  parameter int         SYNC_STAGES  = 2,
  parameter int         OVR_HIGH_CYC = 4
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_SCLK,
  input  logic        i_CSN,
  input  logic        i_MOSI,
  output logic        o_MISO,
  output logic        o_DRDY,
  input  logic        i_PIN_START,
  input  logic        i_PIN_RESETN,
  input  logic        i_SAMPLE_VALID,
  output logic        o_SAMPLE_READY,
  input  logic [23:0] i_CH1,
  input  logic [23:0] i_CH2,
  output logic        o_RDATAC,
  output logic        o_CONVERTING
);

  localparam int            OW       = $clog2(OVR_HIGH_CYC + 1);
  localparam logic [OW-1:0] OVR_LOAD = OW'(OVR_HIGH_CYC);
  localparam logic [6:0]    FRM_BITS = 7'd72;

  typedef enum logic [2:0] {
    ST_OPC,
    ST_CNT,
    ST_WDATA,
    ST_RDATA,
    ST_FRAME
  } state_t;

  // ---------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
  logic [SYNC_STAGES-1:0] rstn_sync_q, rstn_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   csn_prev_q, csn_prev_d;

  logic sclk_s, csn_s, mosi_s, start_s, rstn_s;
  logic sclk_rise, sclk_fall, csn_fall;

  // Shift each pin one stage further down its synchroniser chain.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
    csn_sync_d   = {csn_sync_q[SYNC_STAGES-2:0], i_CSN};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], i_PIN_START};
    rstn_sync_d  = {rstn_sync_q[SYNC_STAGES-2:0], i_PIN_RESETN};
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
    csn_prev_d   = csn_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser flops; only the system reset clears them so that a pin or
  // command reset does not lose track of the live pin levels.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sclk_sync_q  <= '0;
      csn_sync_q   <= '1;
      mosi_sync_q  <= '0;
      start_sync_q <= '0;
      rstn_sync_q  <= '1;
      sclk_prev_q  <= 1'b0;
      csn_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      csn_sync_q   <= csn_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      start_sync_q <= start_sync_d;
      rstn_sync_q  <= rstn_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      csn_prev_q   <= csn_prev_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign start_s   = start_sync_q[SYNC_STAGES-1];
  assign rstn_s    = rstn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  // ---------------------------------------------------------------
  // Core state
  // ---------------------------------------------------------------
  state_t       state_q, state_d;
  logic         rdatac_q, rdatac_d;
  logic         start_cmd_q, start_cmd_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   sh_q, sh_d;
  logic [5:0]   addr_q, addr_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         wr_q, wr_d;
  logic [7:0]   rd_sr_q, rd_sr_d;
  logic [71:0]  buf_q, buf_d;
  logic         full_q, full_d;
  logic         frm_act_q, frm_act_d;
  logic [6:0]   left_q, left_d;
  logic         drdy_q, drdy_d;
  logic [OW-1:0] ovr_q, ovr_d;
  logic         miso_q, miso_d;
  logic [7:0]   regs_q [1:11];
  logic [7:0]   regs_d [1:11];

  logic         byte_done, cmd_rst, rst_all, shift_now, accept, converting;
  logic [7:0]   rx_byte;
  logic [5:0]   rd_addr;
  logic [7:0]   rd_val;
  logic [6:0]   left_base;
  logic         cur_bit;

  assign rx_byte    = {sh_q, mosi_s};
  assign byte_done  = ~csn_s & sclk_fall & (bit_cnt_q == 3'd7);
  assign cmd_rst    = byte_done & (state_q == ST_OPC) & (rx_byte == 8'h06);
  assign rst_all    = i_RST | ~rstn_s | cmd_rst;
  assign shift_now  = ~csn_s & sclk_fall & (frm_act_q | (rdatac_q & full_q));
  assign converting = start_s | start_cmd_q;
  assign accept     = i_SAMPLE_VALID & o_SAMPLE_READY;
  assign left_base  = frm_act_q ? left_q : FRM_BITS;

  // Register read port: the CNT byte fetches reg[addr], later bytes reg[addr+1].
  always_comb begin
    rd_addr = (state_q == ST_CNT) ? addr_q : addr_q + 6'd1;
    rd_val  = 8'h00;
    if (rd_addr == 6'd0) begin
      rd_val = ID_VALUE;
    end else if (rd_addr <= 6'd11) begin
      rd_val = regs_q[rd_addr[3:0]];
    end
  end

  // Bit the responder is currently presenting on MISO.
  always_comb begin
    cur_bit = 1'b0;
    if (rdatac_q || (state_q == ST_FRAME)) begin
      cur_bit = buf_q[71];
    end else if (state_q == ST_RDATA) begin
      cur_bit = rd_sr_q[7];
    end
  end

  // Next-state: byte assembly, command FSM, frame buffer, DRDY timer, MISO.
  always_comb begin
    state_d     = state_q;
    rdatac_d    = rdatac_q;
    start_cmd_d = start_cmd_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_sr_d     = rd_sr_q;
    buf_d       = buf_q;
    full_d      = full_q;
    frm_act_d   = frm_act_q;
    left_d      = left_q;
    drdy_d      = drdy_q;
    ovr_d       = ovr_q;
    miso_d      = miso_q;
    regs_d      = regs_q;

    // CSN high ends any transfer; a half-read frame is thrown away.
    if (csn_s) begin
      bit_cnt_d = 3'd0;
      state_d   = ST_OPC;
      if (frm_act_q) begin
        buf_d     = '0;
        frm_act_d = 1'b0;
      end
    end else if (sclk_fall) begin
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d = 3'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        sh_d      = {sh_q[5:0], mosi_s};
      end
    end

    if (byte_done) begin
      case (state_q)
        ST_OPC: begin
          if (rdatac_q) begin
            if (rx_byte == 8'h11) rdatac_d = 1'b0;
          end else begin
            casez (rx_byte)
              8'h10:        rdatac_d = 1'b1;
              8'h08:        start_cmd_d = 1'b1;
              8'h0A:        start_cmd_d = 1'b0;
              8'h12: begin
                state_d   = ST_FRAME;
                frm_act_d = 1'b1;
                left_d    = FRM_BITS;
              end
              8'b010?_????: begin
                wr_d    = 1'b1;
                addr_d  = {1'b0, rx_byte[4:0]};
                state_d = ST_CNT;
              end
              8'b001?_????: begin
                wr_d    = 1'b0;
                addr_d  = {1'b0, rx_byte[4:0]};
                state_d = ST_CNT;
              end
              default: ;
            endcase
          end
        end
        ST_CNT: begin
          cnt_d = {1'b0, rx_byte[4:0]} + 6'd1;
          if (wr_q) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RDATA;
            rd_sr_d = rd_val;
          end
        end
        ST_WDATA: begin
          if ((addr_q != 6'd0) && (addr_q <= 6'd11)) regs_d[addr_q[3:0]] = rx_byte;
          addr_d = addr_q + 6'd1;
          cnt_d  = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_OPC;
        end
        ST_RDATA: begin
          addr_d = addr_q + 6'd1;
          cnt_d  = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_OPC;
          else               rd_sr_d = rd_val;
        end
        default: ;
      endcase
    end else if ((state_q == ST_RDATA) && !csn_s && sclk_fall) begin
      rd_sr_d = {rd_sr_q[6:0], 1'b0};
    end

    // Overwrite timer: DRDY drops again at terminal count.
    if (ovr_q != '0) begin
      ovr_d = ovr_q - 1'b1;
      if (ovr_q == OW'(1)) drdy_d = 1'b0;
    end

    // Frame readout; the first shifted bit consumes the buffered frame.
    if (shift_now) begin
      buf_d     = {buf_q[70:0], 1'b0};
      left_d    = left_base - 7'd1;
      frm_act_d = (left_base != 7'd1);
      if (full_q) begin
        full_d = 1'b0;
        drdy_d = 1'b1;
        ovr_d  = '0;
      end
      if ((left_base == 7'd1) && (state_q == ST_FRAME)) state_d = ST_OPC;
    end

    // Sample accept; overwriting an unread frame pulses DRDY high.
    if (accept) begin
      buf_d  = {24'hC00000, i_CH1, i_CH2};
      full_d = 1'b1;
      if (full_q) begin
        drdy_d = 1'b1;
        ovr_d  = OVR_LOAD;
      end else begin
        drdy_d = 1'b0;
        ovr_d  = '0;
      end
    end

    if (csn_s)                     miso_d = 1'b0;
    else if (csn_fall || sclk_rise) miso_d = cur_bit;
  end

  // Core registers; system, pin and command reset all land here.
  always_ff @(posedge i_CLK) begin
    if (rst_all) begin
      state_q     <= ST_OPC;
      rdatac_q    <= 1'b1;
      start_cmd_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      sh_q        <= 7'd0;
      addr_q      <= 6'd0;
      cnt_q       <= 6'd0;
      wr_q        <= 1'b0;
      rd_sr_q     <= 8'h00;
      buf_q       <= '0;
      full_q      <= 1'b0;
      frm_act_q   <= 1'b0;
      left_q      <= 7'd0;
      drdy_q      <= 1'b1;
      ovr_q       <= '0;
      miso_q      <= 1'b0;
      for (int i = 1; i <= 11; i++) regs_q[i] <= (i == 1) ? 8'h02 : 8'h00;
    end else begin
      state_q     <= state_d;
      rdatac_q    <= rdatac_d;
      start_cmd_q <= start_cmd_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_sr_q     <= rd_sr_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      frm_act_q   <= frm_act_d;
      left_q      <= left_d;
      drdy_q      <= drdy_d;
      ovr_q       <= ovr_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
    end
  end

  assign o_MISO         = miso_q;
  assign o_DRDY         = drdy_q;
  assign o_RDATAC       = rdatac_q;
  assign o_CONVERTING   = converting;
  assign o_SAMPLE_READY = converting & ~frm_act_q & ~shift_now;

endmodule

// File: tb/tb_ads1292_spi_responder.sv
// Directed bench for ads1292_spi_responder: acts as the SPI master and
// sample source, checks register access, frames, DRDY and resets.
module tb_ads1292_spi_responder;

  logic        clk = 1'b0;
  logic        i_RST, i_SCLK, i_CSN, i_MOSI, i_PIN_START, i_PIN_RESETN, i_SAMPLE_VALID;
  logic [23:0] i_CH1, i_CH2;
  logic        o_MISO, o_DRDY, o_SAMPLE_READY, o_RDATAC, o_CONVERTING;

  int n_checks = 0;
  int n_fail   = 0;

  ads1292_spi_responder dut (
    .i_CLK          (clk),
    .i_RST          (i_RST),
    .i_SCLK         (i_SCLK),
    .i_CSN          (i_CSN),
    .i_MOSI         (i_MOSI),
    .o_MISO         (o_MISO),
    .o_DRDY         (o_DRDY),
    .i_PIN_START    (i_PIN_START),
    .i_PIN_RESETN   (i_PIN_RESETN),
    .i_SAMPLE_VALID (i_SAMPLE_VALID),
    .o_SAMPLE_READY (o_SAMPLE_READY),
    .i_CH1          (i_CH1),
    .i_CH2          (i_CH2),
    .o_RDATAC       (o_RDATAC),
    .o_CONVERTING   (o_CONVERTING)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    i_CSN = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(8);
    i_CSN = 1'b1;
    wait_clk(8);
  endtask

  // Mode-1 master: drive MOSI and raise SCLK, sample MISO late in the high
  // phase, then drop SCLK (the responder samples MOSI on that fall).
  task automatic spi_shift(input int n, input logic [71:0] tx, output logic [71:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      i_MOSI = tx[i];
      i_SCLK = 1'b1;
      wait_clk(8);
      rx = {rx[70:0], o_MISO};
      i_SCLK = 1'b0;
      wait_clk(8);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic [71:0] r;
    spi_shift(8, {64'd0, tx}, r);
    rx = r[7:0];
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] d;
    xfer(tx, d);
  endtask

  task automatic send_sample(input logic [23:0] c1, input logic [23:0] c2);
    i_CH1 = c1;
    i_CH2 = c2;
    i_SAMPLE_VALID = 1'b1;
    @(negedge clk);
    i_SAMPLE_VALID = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  r1, r2, r3;
    logic [71:0] b1, b2;
    int          hi_cnt;

    i_RST = 1'b1; i_SCLK = 1'b0; i_CSN = 1'b1; i_MOSI = 1'b0;
    i_PIN_START = 1'b0; i_PIN_RESETN = 1'b1; i_SAMPLE_VALID = 1'b0;
    i_CH1 = '0; i_CH2 = '0;
    wait_clk(5);
    i_RST = 1'b0;
    wait_clk(2);
    chk("rst_miso", o_MISO, 0);
    chk("rst_drdy", o_DRDY, 1);
    chk("rst_rdatac", o_RDATAC, 1);
    chk("rst_conv", o_CONVERTING, 0);
    chk("rst_ready", o_SAMPLE_READY, 0);

    // RDATAC after reset: RREG must be ignored.
    cs_low(); send(8'h20); send(8'h01); xfer(8'h00, r1); cs_high();
    chk("rdatac_ignores_rreg", r1, 8'h00);
    chk("rdatac_still_set", o_RDATAC, 1);

    cs_low(); send(8'h11); cs_high();
    chk("sdatac_clears", o_RDATAC, 0);

    cs_low(); send(8'h20); send(8'h01); xfer(8'h00, r1); xfer(8'h00, r2); cs_high();
    chk("rreg_id", r1, 8'h73);
    chk("rreg_reg1", r2, 8'h02);

    cs_low(); send(8'h42); send(8'h01); send(8'hA5); send(8'h3C); cs_high();
    cs_low(); send(8'h22); send(8'h01); xfer(8'h00, r1); xfer(8'h00, r2); cs_high();
    chk("wreg_reg2", r1, 8'hA5);
    chk("wreg_reg3", r2, 8'h3C);

    cs_low(); send(8'h40); send(8'h00); send(8'h00); cs_high();
    cs_low(); send(8'h20); send(8'h00); xfer(8'h00, r1); cs_high();
    chk("reg0_readonly", r1, 8'h73);

    // reg11 written, addr 12 dropped, reads past 11 give zero.
    cs_low(); send(8'h4B); send(8'h01); send(8'h5A); send(8'h77); cs_high();
    cs_low(); send(8'h2A); send(8'h02); xfer(8'h00, r1); xfer(8'h00, r2); xfer(8'h00, r3); cs_high();
    chk("rreg_reg10", r1, 8'h00);
    chk("rreg_reg11", r2, 8'h5A);
    chk("rreg_reg12", r3, 8'h00);

    // Frame readout in RDATAC.
    cs_low(); send(8'h10); cs_high();
    chk("rdatac_set", o_RDATAC, 1);
    i_PIN_START = 1'b1;
    wait_clk(6);
    chk("pin_start_conv", o_CONVERTING, 1);
    chk("ready_idle", o_SAMPLE_READY, 1);
    send_sample(24'h123456, 24'hFEDCBA);
    chk("drdy_low_on_accept", o_DRDY, 0);
    cs_low();
    chk("drdy_low_before_read", o_DRDY, 0);
    spi_shift(1, '0, b1);
    chk("drdy_high_first_fall", o_DRDY, 1);
    chk("ready_low_shifting", o_SAMPLE_READY, 0);
    spi_shift(71, '0, b2);
    cs_high();
    chk("frame1", {b1[0], b2[70:0]}, 72'hC00000123456FEDCBA);

    // Overwrite of an unread frame.
    send_sample(24'h111111, 24'h222222);
    chk("drdy_low_first", o_DRDY, 0);
    i_CH1 = 24'hABCDEF;
    i_CH2 = 24'h012345;
    i_SAMPLE_VALID = 1'b1;
    @(negedge clk);
    i_SAMPLE_VALID = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_DRDY) hi_cnt++;
      @(negedge clk);
    end
    chk("ovr_high_cycles", hi_cnt, 4);
    chk("ovr_drdy_low_after", o_DRDY, 0);
    cs_low(); spi_shift(72, '0, b1); cs_high();
    chk("frame_overwrite", b1, 72'hC00000ABCDEF012345);

    // CSN abort after 13 frame bits.
    send_sample(24'h800001, 24'h7FFFFE);
    cs_low(); spi_shift(13, '0, b1); cs_high();
    chk("abort_13_bits", b1[12:0], 13'h1800);
    cs_low(); spi_shift(8, '0, b1);
    chk("abort_rest_zero", b1[7:0], 8'h00);
    chk("abort_drdy_high", o_DRDY, 1);
    cs_high();

    // CSN abort mid WREG data byte leaves register untouched.
    i_PIN_START = 1'b0;
    cs_low(); send(8'h11); cs_high();
    cs_low(); send(8'h43); send(8'h00); spi_shift(4, 72'hF, b1); cs_high();
    cs_low(); send(8'h23); send(8'h00); xfer(8'h00, r1); cs_high();
    chk("wreg_abort_reg3", r1, 8'h3C);

    // Pin reset during RREG.
    cs_low(); send(8'h41); send(8'h00); send(8'h55); cs_high();
    cs_low(); send(8'h08); cs_high();
    chk("start_cmd_conv", o_CONVERTING, 1);
    send_sample(24'h000001, 24'h000002);
    chk("pre_reset_drdy", o_DRDY, 0);
    cs_low(); send(8'h21); send(8'h00); spi_shift(3, '0, b1);
    i_PIN_RESETN = 1'b0;
    wait_clk(6);
    i_PIN_RESETN = 1'b1;
    wait_clk(6);
    chk("pinrst_drdy", o_DRDY, 1);
    chk("pinrst_rdatac", o_RDATAC, 1);
    chk("pinrst_conv", o_CONVERTING, 0);
    chk("pinrst_ready", o_SAMPLE_READY, 0);
    cs_high();
    cs_low(); send(8'h11); send(8'h20); send(8'h01); xfer(8'h00, r1); xfer(8'h00, r2); cs_high();
    chk("pinrst_reg0", r1, 8'h73);
    chk("pinrst_reg1", r2, 8'h02);

    // RESET command from SDATAC mode.
    cs_low(); send(8'h06); cs_high();
    chk("cmd_reset_rdatac", o_RDATAC, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
